// File: rtl/udm_arb_pkg.sv
// udm_arb_pkg: shared encodings for the udm two-master bus arbiter.
//   gnt_e      : registered grant state (NONE / M0 / M1), also used for the
//                last-granted pointer.
//   PRIO_FIXED : m0 always wins a tie.
//   PRIO_RR    : a tie goes to the master that was not granted last.
package udm_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_e;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

endpackage : udm_arb_pkg

// File: rtl/udm_arb_owner_fifo.sv
// udm_arb_owner_fifo: 1-bit wide owner FIFO recording which master issued
// each accepted read, so responses can be routed back in issue order.
//   clk_i, rst_i : clock, asynchronous active-high reset (clears contents)
//   push_i/din_i : append owner bit (0 = m0, 1 = m1)
//   pop_i        : drop the head entry
//   head_o       : owner of the oldest outstanding read
//   count_o      : number of entries, 0..DEPTH
//   full_o/empty_o
// The caller never pushes into a full FIFO without a simultaneous pop and
// never pops an empty one; the FIFO does not re-check this.
module udm_arb_owner_fifo #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             din_i,
  output logic             head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule : udm_arb_owner_fifo

// File: rtl/udm_bus_arb.sv
// udm_bus_arb: shares one split-transaction slave bus between the udm debug
// master (m0) and the core data port (m1).
//   m0_*/m1_*   : master request side (req/we/addr/be/wdata in,
//                 ack/resp/rdata out)
//   s_*         : slave side (req/we/addr/be/wdata out, ack/resp/rdata in)
//   err_o       : sticky, set when a response arrives with no read pending
// A grant is held from the IDLE decision until the slave acks the address
// phase. Accepted reads record their owner so the later response is routed
// back to the issuing master.
module udm_bus_arb
  import udm_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_FIXED,
  parameter int RD_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,
  output logic        err_o
);

  localparam int CNT_W = $clog2(RD_DEPTH + 1);

  gnt_e             gnt_q, gnt_d;
  gnt_e             lp_q, lp_d;
  logic             err_q, err_d;
  gnt_e             pick;
  logic             rd_slot_free;
  logic             m0_elig, m1_elig;
  logic             fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // The pre-pop count decides eligibility: a response in the same cycle
  // does not free a slot for this decision. Writes are never blocked.
  assign rd_slot_free = (fifo_count != CNT_W'(RD_DEPTH));
  assign m0_elig      = m0_req_i && (m0_we_i || rd_slot_free);
  assign m1_elig      = m1_req_i && (m1_we_i || rd_slot_free);

  always_comb begin
    pick = GNT_NONE;
    if (m0_elig && m1_elig) begin
      // In round-robin the master that did not win last time goes first.
      if (PRIO_MODE == PRIO_RR && lp_q == GNT_M0) pick = GNT_M1;
      else                                        pick = GNT_M0;
    end else if (m0_elig) begin
      pick = GNT_M0;
    end else if (m1_elig) begin
      pick = GNT_M1;
    end
  end

  always_comb begin
    gnt_d = gnt_q;
    lp_d  = lp_q;
    if (gnt_q == GNT_NONE) begin
      gnt_d = pick;
      if (pick != GNT_NONE) lp_d = pick;
    end else if (s_ack_i) begin
      // Always return to IDLE for one cycle after an address phase.
      gnt_d = GNT_NONE;
    end
  end

  assign err_d = err_q | (s_resp_i & fifo_empty);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q <= GNT_NONE;
      lp_q  <= GNT_M1;
      err_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      lp_q  <= lp_d;
      err_q <= err_d;
    end
  end

  // Address-phase mux: everything is zero while no master holds the grant.
  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    case (gnt_q)
      GNT_M0: begin
        s_req_o    = m0_req_i;
        s_we_o     = m0_we_i;
        s_addr_bo  = m0_addr_bi;
        s_be_bo    = m0_be_bi;
        s_wdata_bo = m0_wdata_bi;
        m0_ack_o   = s_ack_i;
      end
      GNT_M1: begin
        s_req_o    = m1_req_i;
        s_we_o     = m1_we_i;
        s_addr_bo  = m1_addr_bi;
        s_be_bo    = m1_be_bi;
        s_wdata_bo = m1_wdata_bi;
        m1_ack_o   = s_ack_i;
      end
      default: ;
    endcase
  end

  assign fifo_pop  = s_resp_i & ~fifo_empty;
  assign fifo_push = s_req_o & s_ack_i & ~s_we_o & (~fifo_full | fifo_pop);

  udm_arb_owner_fifo #(
    .DEPTH (RD_DEPTH)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (gnt_q == GNT_M1),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Response routing: only the head owner sees resp and data.
  assign m0_resp_o   = fifo_pop & ~fifo_head;
  assign m1_resp_o   = fifo_pop & fifo_head;
  assign m0_rdata_bo = {32{m0_resp_o}} & s_rdata_bi;
  assign m1_rdata_bo = {32{m1_resp_o}} & s_rdata_bi;

  assign err_o = err_q;

endmodule : udm_bus_arb
